// File: rtl/mem_ctrl.sv
// Byte-serial controller sharing one 8-bit RAM port between instruction fetch and the MEM stage.
// MEM wins arbitration; reads and writes are sequenced little-endian, one byte per cycle.
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_inst,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [1:0]  mem_size,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_done,
    output logic [31:0] mem_rdata,
    input  logic [7:0]  ram_din,
    output logic [7:0]  ram_dout,
    output logic [31:0] ram_a,
    output logic        ram_wr
);

    typedef enum logic [1:0] {IDLE, IF_READ, MEM_READ, MEM_WRITE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  nbytes_q, nbytes_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] ram_a_q, ram_a_d;
    logic [7:0]  ram_dout_q, ram_dout_d;
    logic        ram_wr_q, ram_wr_d;
    logic        if_done_q, if_done_d;
    logic        mem_done_q, mem_done_d;
    logic [31:0] if_inst_q, if_inst_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic [2:0]  mem_n;
    logic [2:0]  next_k;
    logic        grant_ok;

    assign next_k   = cnt_q + 3'd1;
    // The done cycle is spent in IDLE without sampling requests.
    assign grant_ok = !(if_done_q || mem_done_q);

    always_comb begin
        case (mem_size)
            2'd0:    mem_n = 3'd1;
            2'd1:    mem_n = 3'd2;
            default: mem_n = 3'd4;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_ok) begin
                    if (mem_req) begin
                        state_d = mem_we ? MEM_WRITE : MEM_READ;
                    end else if (if_req && !clear) begin
                        state_d = IF_READ;
                    end
                end
            end
            IF_READ: begin
                if (clear || cnt_q == nbytes_q) begin
                    state_d = IDLE;
                end
            end
            MEM_READ: begin
                if (cnt_q == nbytes_q) begin
                    state_d = IDLE;
                end
            end
            MEM_WRITE: begin
                if (next_k == nbytes_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        nbytes_d    = nbytes_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        buf_d       = buf_q;
        ram_a_d     = '0;
        ram_dout_d  = '0;
        ram_wr_d    = 1'b0;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
        if_inst_d   = if_inst_q;
        mem_rdata_d = mem_rdata_q;
        case (state_q)
            IDLE: begin
                if (state_d != IDLE) begin
                    cnt_d = '0;
                    buf_d = '0;
                    if (state_d == IF_READ) begin
                        addr_d   = if_addr;
                        nbytes_d = 3'd4;
                    end else begin
                        addr_d   = mem_addr;
                        nbytes_d = mem_n;
                        wdata_d  = mem_wdata;
                    end
                    ram_a_d  = addr_d;
                    ram_wr_d = (state_d == MEM_WRITE);
                    if (state_d == MEM_WRITE) begin
                        ram_dout_d = mem_wdata[7:0];
                    end
                end
            end
            IF_READ, MEM_READ: begin
                // ram_din now carries the byte addressed in the previous cycle.
                if (cnt_q != 3'd0) begin
                    buf_d = buf_q | (32'(ram_din) << {cnt_q - 3'd1, 3'b000});
                end
                if (state_d == IDLE) begin
                    cnt_d = '0;
                    if (state_q == MEM_READ) begin
                        mem_done_d  = 1'b1;
                        mem_rdata_d = buf_d;
                    end else if (!clear) begin
                        if_done_d = 1'b1;
                        if_inst_d = buf_d;
                    end
                end else begin
                    cnt_d = next_k;
                    if (next_k < nbytes_q) begin
                        ram_a_d = addr_q + 32'(next_k);
                    end
                end
            end
            MEM_WRITE: begin
                if (state_d == IDLE) begin
                    cnt_d      = '0;
                    mem_done_d = 1'b1;
                end else begin
                    cnt_d      = next_k;
                    ram_a_d    = addr_q + 32'(next_k);
                    ram_wr_d   = 1'b1;
                    ram_dout_d = 8'(wdata_q >> {next_k, 3'b000});
                end
            end
            default: cnt_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            nbytes_q    <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            buf_q       <= '0;
            ram_a_q     <= '0;
            ram_dout_q  <= '0;
            ram_wr_q    <= 1'b0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            if_inst_q   <= '0;
            mem_rdata_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            nbytes_q    <= nbytes_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            buf_q       <= buf_d;
            ram_a_q     <= ram_a_d;
            ram_dout_q  <= ram_dout_d;
            ram_wr_q    <= ram_wr_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            if_inst_q   <= if_inst_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    assign if_done   = if_done_q;
    assign if_inst   = if_inst_q;
    assign mem_done  = mem_done_q;
    assign mem_rdata = mem_rdata_q;
    assign ram_a     = ram_a_q;
    assign ram_dout  = ram_dout_q;
    assign ram_wr    = ram_wr_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: a byte RAM model, a golden byte memory that predicts
// every load/fetch result, and a monitor that checks each done pulse against the queue.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst, clear, if_req, mem_req, mem_we;
    logic [31:0] if_addr, mem_addr, mem_wdata;
    logic [1:0]  mem_size;
    logic        if_done, mem_done, ram_wr;
    logic [31:0] if_inst, mem_rdata, ram_a;
    logic [7:0]  ram_din, ram_dout;

    always #5 clk = ~clk;

    mem_ctrl dut (
        .clk(clk), .rst(rst), .clear(clear),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_inst(if_inst),
        .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
        .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr)
    );

    logic [7:0]  ram  [logic [31:0]];
    logic [7:0]  gmem [logic [31:0]];
    logic [31:0] if_exp[$];
    logic [31:0] mem_exp[$];
    logic [31:0] last_inst, last_rdata;
    int          checks = 0;
    int          errors = 0;
    bit          prev_done = 1'b0;

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        case (a)
            32'h100:          return 8'h13;
            32'h101:          return 8'h05;
            32'h102, 32'h103: return 8'h00;
            32'h30:           return 8'h80;
            default:          return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'hA5;
        endcase
    endfunction

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] gmem_rd(input logic [31:0] a);
        return gmem.exists(a) ? gmem[a] : init_byte(a);
    endfunction

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    // RAM: one-cycle read latency, write on ram_wr
    initial begin
        forever begin
            @(posedge clk);
            if (ram_wr) ram[ram_a] = ram_dout;
            ram_din <= ram_rd(ram_a);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: pulse with no expected response at %0t", nm, $time);
    endtask

    // Monitor: pops the scoreboard whenever a done pulse appears
    initial begin
        forever begin
            @(posedge clk); #1;
            if (if_done || mem_done) begin
                chk("done_overlap", 32'(if_done & mem_done), 32'd0);
                chk("done_back_to_back", 32'(prev_done), 32'd0);
            end
            if (if_done) begin
                if (if_exp.size() == 0) unexpected("if_done");
                else chk("if_inst", if_inst, if_exp.pop_front());
            end
            if (mem_done) begin
                if (mem_exp.size() == 0) unexpected("mem_done");
                else chk("mem_rdata", mem_rdata, mem_exp.pop_front());
            end
            prev_done = if_done | mem_done;
        end
    end

    // One transaction from a single requester; returns in the cycle after the done cycle.
    task automatic txn(input bit is_if, input bit we, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wd, input bit hold_clear);
        int n, lat, exp_lat;
        logic [31:0] v;
        bit wr;
        wr = !is_if && we;
        n = is_if ? 4 : nbytes(size);
        exp_lat = wr ? n + 1 : n + 2;
        v = '0;
        for (int k = 0; k < n; k++) v |= 32'(gmem_rd(addr + 32'(k))) << (8 * k);
        if (is_if) begin
            if_exp.push_back(v);
            last_inst = v;
        end else if (wr) begin
            for (int k = 0; k < n; k++) gmem[addr + 32'(k)] = wd[8*k +: 8];
            mem_exp.push_back(last_rdata);
        end else begin
            mem_exp.push_back(v);
            last_rdata = v;
        end
        if (is_if) begin
            if_req = 1'b1; if_addr = addr;
        end else begin
            mem_req = 1'b1; mem_we = we; mem_size = size; mem_addr = addr; mem_wdata = wd;
        end
        clear = hold_clear;
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin
                if_addr   = $urandom;
                mem_addr  = $urandom;
                mem_wdata = $urandom;
                mem_size  = 2'($urandom_range(0, 3));
            end
            if (i <= n) begin
                chk("ram_a", ram_a, addr + 32'(i - 1));
                chk("ram_wr", 32'(ram_wr), 32'(wr));
                if (wr) chk("ram_dout", 32'(ram_dout), 32'(wd[8*(i-1) +: 8]));
            end
            if (is_if ? if_done : mem_done) lat = i;
        end
        chk(is_if ? "if_latency" : "mem_latency", lat, exp_lat);
        if (lat != 0) begin
            chk("done_ram_wr", 32'(ram_wr), 32'd0);
            chk("done_ram_a", ram_a, 32'd0);
        end
        if_req = 1'b0; mem_req = 1'b0; clear = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int cnt, lat;
        logic [31:0] a;
        rst = 1'b1; clear = 1'b0; if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
        mem_size = '0; if_addr = '0; mem_addr = '0; mem_wdata = '0;
        last_inst = '0; last_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_if_done", 32'(if_done), 0);
        chk("rst_mem_done", 32'(mem_done), 0);
        chk("rst_ram_wr", 32'(ram_wr), 0);
        chk("rst_ram_a", ram_a, 0);
        chk("rst_ram_dout", 32'(ram_dout), 0);
        chk("rst_if_inst", if_inst, 0);
        chk("rst_mem_rdata", mem_rdata, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        txn(1'b1, 1'b0, 2'd2, 32'h100, '0, 1'b0);
        chk("fetch_0x100", if_inst, 32'h00000513);

        txn(1'b0, 1'b1, 2'd2, 32'h2000, 32'hDEADBEEF, 1'b0);
        txn(1'b0, 1'b0, 2'd1, 32'h2002, '0, 1'b0);
        chk("half_load_0x2002", mem_rdata, 32'h0000DEAD);

        // Contention: MEM first, IF granted right after the done cycle
        v_contention: begin
            logic [31:0] iv;
            iv = '0;
            for (int k = 0; k < 4; k++) iv |= 32'(gmem_rd(32'h40 + 32'(k))) << (8 * k);
            mem_exp.push_back({24'h0, gmem_rd(32'h30)});
            last_rdata = {24'h0, gmem_rd(32'h30)};
            if_exp.push_back(iv);
            last_inst = iv;
            if_req = 1'b1; if_addr = 32'h40;
            mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd0; mem_addr = 32'h30;
            lat = 0; cnt = 0;
            for (int i = 1; i <= 20 && lat == 0; i++) begin
                @(posedge clk); #1;
                if (if_done) cnt++;
                if (mem_done) lat = i;
            end
            chk("contention_mem_latency", lat, 3);
            chk("contention_if_early", cnt, 0);
            chk("contention_rdata", mem_rdata, 32'h00000080);
            mem_req = 1'b0;
            lat = 0;
            for (int i = 1; i <= 20 && lat == 0; i++) begin
                @(posedge clk); #1;
                if (if_done) lat = i;
            end
            chk("contention_if_after_mem", lat, 7);
            if_req = 1'b0;
            @(posedge clk); #1;
        end

        // clear in IF_READ cycle c2 aborts the fetch
        if_req = 1'b1; if_addr = 32'h200;
        cnt = 0;
        for (int i = 1; i <= 14; i++) begin
            @(posedge clk); #1;
            if (if_done) cnt++;
            if (i == 3) clear = 1'b1;
            if (i == 4) begin clear = 1'b0; if_req = 1'b0; end
        end
        chk("flush_no_done", cnt, 0);
        chk("flush_inst_hold", if_inst, last_inst);

        // clear in IDLE blocks the IF grant
        clear = 1'b1; if_req = 1'b1; if_addr = 32'h104;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("clear_idle_no_grant", ram_a, 32'd0);
        end
        clear = 1'b0;
        txn(1'b1, 1'b0, 2'd2, 32'h104, '0, 1'b0);

        // clear is ignored during a store
        txn(1'b0, 1'b1, 2'd2, 32'h2100, 32'hCAFEF00D, 1'b1);
        txn(1'b0, 1'b0, 2'd2, 32'h2100, '0, 1'b0);

        // Reset after two bytes of a word store
        mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd2; mem_addr = 32'h3000; mem_wdata = 32'h11223344;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_ram_wr", 32'(ram_wr), 0);
        chk("midrst_ram_a", ram_a, 0);
        chk("midrst_ram_dout", 32'(ram_dout), 0);
        chk("midrst_mem_done", 32'(mem_done), 0);
        chk("midrst_mem_rdata", mem_rdata, 0);
        chk("midrst_if_inst", if_inst, 0);
        rst = 1'b0; mem_req = 1'b0;
        gmem[32'h3000] = 8'h44;
        gmem[32'h3001] = 8'h33;
        last_rdata = '0; last_inst = '0;
        @(posedge clk); #1;
        txn(1'b0, 1'b0, 2'd2, 32'h3000, '0, 1'b0);

        // Address wrap
        txn(1'b0, 1'b0, 2'd2, 32'hFFFFFFFE, '0, 1'b0);

        // Randomized traffic
        for (int t = 0; t < 80; t++) begin
            if ($urandom_range(0, 7) == 0) a = 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
            else a = 32'h1000 + 32'($urandom_range(0, 63));
            case ($urandom_range(0, 2))
                0: txn(1'b1, 1'b0, 2'd2, a, '0, 1'b0);
                1: txn(1'b0, 1'b0, 2'($urandom_range(0, 3)), a, '0, 1'($urandom_range(0, 1)));
                default: txn(1'b0, 1'b1, 2'($urandom_range(0, 3)), a, $urandom, 1'($urandom_range(0, 1)));
            endcase
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        repeat (4) @(posedge clk);
        #1;
        chk("if_queue_empty", 32'(if_exp.size()), 0);
        chk("mem_queue_empty", 32'(mem_exp.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Byte-serial memory controller sharing the single 8-bit RAM port between instruction fetch (IF) and the MEM stage. It accepts one request at a time and grants MEM over IF. It sequences 1, 2 or 4 byte-wide RAM cycles, little-endian, and returns a one-cycle done pulse with the assembled 32-bit data. It sits between the IF/MEM stages (downstream of EX_MEM) and the external RAM.

## Interface
- Parameters: none. Widths come from Defines.v: `InstAddrBus` = 32, `regbus` = 32.
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset (`rst_enable`).
- clear  in  1  pipeline flush (branch mispredict); cancels IF traffic only.
- if_req  in  1  IF fetch request; level, held until if_done.
- if_addr  in  32  fetch address.
- if_done  out  1  one-cycle pulse; if_inst valid.
- if_inst  out  32  fetched word; holds until next if_done.
- mem_req  in  1  MEM request; level, held until mem_done.
- mem_we  in  1  1 = store, 0 = load.
- mem_size  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
- mem_addr  in  32  byte address; no alignment required.
- mem_wdata  in  32  store data; low bytes are used.
- mem_done  out  1  one-cycle pulse; load or store complete.
- mem_rdata  out  32  load data, zero-extended (MEM stage sign-extends); holds until next load done.
- ram_din  in  8  RAM read data; 1-cycle latency after ram_a.
- ram_dout  out  8  RAM write data.
- ram_a  out  32  RAM byte address.
- ram_wr  out  1  1 = write this cycle.

## Operation
- States: IDLE, IF_READ, MEM_READ, MEM_WRITE.
- Byte counts: N = 1/2/4 from mem_size; IF is always 4.
- All outputs are registered.
- Reset: every output is 0, the state is IDLE, and the byte counter is 0. Reset aborts any transaction in flight without a done pulse.
- IDLE arbitration at posedge:
  - mem_req → MEM_READ or MEM_WRITE per mem_we.
  - else if_req && !clear → IF_READ.
  - The request address, size and wdata are latched at grant; later changes on the request inputs are ignored.
  - No preemption: a granted transaction always completes, except for clear on IF.
- Read, N bytes, cycles c0..cN after grant:
  - In ck (k < N): ram_a = addr + k, ram_wr = 0.
  - At end of c(k+1): byte k is captured from ram_din into bits [8k+7:8k].
  - After end of cN: state returns to IDLE and the done pulse is asserted the following cycle.
  - Unfilled high bytes are 0.
- Write, N bytes, cycles c0..c(N-1):
  - ram_a = addr + k, ram_dout = mem_wdata[8k+7:8k], ram_wr = 1.
  - Next cycle: IDLE with mem_done = 1, ram_wr = 0.
- Address arithmetic is 32-bit modulo: 0xFFFFFFFF + 1 = 0x00000000.
- Done cycle: the state is IDLE, but requests are not sampled for grant in this cycle. This lets the requester drop or replace req. Arbitration resumes the next cycle.
- clear:
  - In IDLE, it blocks an IF grant that cycle.
  - During IF_READ, it aborts to IDLE at that edge. There is no if_done and if_inst is unchanged.
  - It is ignored during MEM_READ and MEM_WRITE.
- In IDLE, ram_wr = 0, ram_a = 0 and ram_dout = 0.
- Simultaneous if_req and mem_req: MEM is served first. IF is granted on the first eligible IDLE cycle after mem_done.

## Timing
- Req high in IDLE cycle t (not a done cycle) → grant edge end of t → c0 = t+1.
- Read done pulse at t+N+2. A word fetch with req at cycle 0 gives done at cycle 6.
- Write done pulse at t+N+1. A word store gives done at cycle 5.
- Back-to-back from the same requester: minimum spacing between done pulses is N+3 cycles for reads and N+2 for writes. This includes the done-cycle gap.
- ram_wr is never high outside MEM_WRITE.
- if_done and mem_done are never high together and never high for 2 consecutive cycles.

## Test plan
- Reset then IF fetch: RAM[0x100..0x103] = 13,05,00,00, if_req at cycle 0 with addr 0x100 → if_done at cycle 6, if_inst = 0x00000513. No ram_wr, and ram_a sequence 0x100..0x103.
- Word store then half load: mem_we = 1, size 2, addr 0x2000, wdata 0xDEADBEEF → ram_wr 4 cycles with bytes EF, BE, AD, DE, and mem_done 5 cycles after request. Then a half load from 0x2002 → mem_rdata = 0x0000DEAD.
- Contention: if_req and mem_req (byte load at 0x30 = 0x80) asserted together → mem_done first with mem_rdata = 0x00000080. IF is granted in the IDLE cycle after the done cycle.
- Flush: clear pulses in cycle c2 of IF_READ → state IDLE, no if_done, if_inst unchanged. Clear during a MEM_WRITE → all 4 writes occur and mem_done still pulses.
- Reset mid-store after 2 bytes written → ram_wr = 0 next cycle, no mem_done, all outputs 0. The next request starts cleanly.
- Wrap: word load at 0xFFFFFFFE → ram_a sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001.
